// File: rtl/exmem_pipe_reg_if.sv
// EX/MEM handshake bundle: EX-side entry fields plus MEM-side registered outputs.
// The slave modport is the pipeline register; the master modport drives EX and consumes MEM.
interface exmem_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out_ex;
  logic [SEL_W-1:0]  dselect_ex;
  logic [DATA_W-1:0] store_data_ex;
  logic              sw_ex;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dbus;
  logic [SEL_W-1:0]  dselect;
  logic [DATA_W-1:0] databus_in;
  logic              sw_mem;

  modport slave (
    input  in_valid, alu_out_ex, dselect_ex, store_data_ex, sw_ex, out_ready,
    output in_ready, out_valid, dbus, dselect, databus_in, sw_mem
  );

  modport master (
    output in_valid, alu_out_ex, dselect_ex, store_data_ex, sw_ex, out_ready,
    input  in_ready, out_valid, dbus, dselect, databus_in, sw_mem
  );
endinterface

// File: rtl/exmem_pipe_reg.sv
// Elastic EX/MEM pipeline register: main entry plus one-entry skid, synchronous flush.
// Optional MEM back-pressure counter enabled by defining EXMEM_STALL_CNT_EN.
module exmem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  exmem_pipe_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic [DATA_W-1:0] main_alu_reg;
  logic [SEL_W-1:0]  main_dsel_reg;
  logic [DATA_W-1:0] main_sdata_reg;
  logic              main_sw_reg;
  logic [DATA_W-1:0] skid_alu_reg;
  logic [SEL_W-1:0]  skid_dsel_reg;
  logic [DATA_W-1:0] skid_sdata_reg;
  logic              skid_sw_reg;

  logic main_valid;
  logic take_in;
  logic take_out;

  assign main_valid = (state_reg != EMPTY);
  // in_ready comes straight from a flop, so out_ready never reaches EX combinationally
  assign take_in    = bus.in_valid & in_ready_reg;
  assign take_out   = main_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      main_alu_reg   <= '0;
      main_dsel_reg  <= '0;
      main_sdata_reg <= '0;
      main_sw_reg    <= 1'b0;
      skid_alu_reg   <= '0;
      skid_dsel_reg  <= '0;
      skid_sdata_reg <= '0;
      skid_sw_reg    <= 1'b0;
    end else if (flush) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (take_in) begin
            main_alu_reg   <= bus.alu_out_ex;
            main_dsel_reg  <= bus.dselect_ex;
            main_sdata_reg <= bus.store_data_ex;
            main_sw_reg    <= bus.sw_ex;
            state_reg      <= ONE;
          end
        end
        ONE: begin
          if (take_in && take_out) begin
            main_alu_reg   <= bus.alu_out_ex;
            main_dsel_reg  <= bus.dselect_ex;
            main_sdata_reg <= bus.store_data_ex;
            main_sw_reg    <= bus.sw_ex;
          end else if (take_in) begin
            skid_alu_reg   <= bus.alu_out_ex;
            skid_dsel_reg  <= bus.dselect_ex;
            skid_sdata_reg <= bus.store_data_ex;
            skid_sw_reg    <= bus.sw_ex;
            state_reg      <= FULL;
            in_ready_reg   <= 1'b0;
          end else if (take_out) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (take_out) begin
            main_alu_reg   <= skid_alu_reg;
            main_dsel_reg  <= skid_dsel_reg;
            main_sdata_reg <= skid_sdata_reg;
            main_sw_reg    <= skid_sw_reg;
            state_reg      <= ONE;
            in_ready_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = main_valid;
  assign bus.dbus       = main_alu_reg;
  assign bus.dselect    = main_dsel_reg;
  assign bus.databus_in = main_sdata_reg;
  assign bus.sw_mem     = main_sw_reg & main_valid;

`ifdef EXMEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Saturating; flush deliberately leaves the count alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && !bus.out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg: a two-deep FIFO reference model tracks what MEM should see.
// Directed scenarios are followed by randomized traffic with occasional flush and reset.
module tb_exmem_pipe_reg;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 32;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] alu;
    logic [SEL_W-1:0]  dsel;
    logic [DATA_W-1:0] sdata;
    logic              sw;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  exmem_pipe_reg_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  exmem_pipe_reg #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t q[$];
  ent_t hold;
  int   exp_cnt;
  int   checks_total;
  int   checks_passed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: the register is a FIFO of depth two, with in_ready meaning "fewer than two held"
  always @(posedge clk) begin
    int n;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      hold    = '{alu: '0, dsel: '0, sdata: '0, sw: 1'b0};
      exp_cnt = 0;
    end else begin
      n = q.size();
`ifdef EXMEM_STALL_CNT_EN
      if (n != 0 && !bus.out_ready && exp_cnt < (2**CNT_W) - 1) exp_cnt++;
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (n != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && n < 2) begin
          e.alu   = bus.alu_out_ex;
          e.dsel  = bus.dselect_ex;
          e.sdata = bus.store_data_ex;
          e.sw    = bus.sw_ex;
          q.push_back(e);
        end
      end
      if (q.size() != 0) hold = q[0];
    end
  end

  // Monitor: compares DUT outputs against the model shortly after every edge
  always @(posedge clk) begin
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("dbus", 64'(bus.dbus), 64'(hold.alu));
    chk("dselect", 64'(bus.dselect), 64'(hold.dsel));
    chk("databus_in", 64'(bus.databus_in), 64'(hold.sdata));
    chk("sw_mem", 64'(bus.sw_mem), 64'((q.size() != 0) ? hold.sw : 1'b0));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    $display("t=%0t rst_n=%0b flush=%0b in_v=%0b out_v=%0b out_r=%0b in_r=%0b dbus=%08h sw_mem=%0b cnt=%0d",
             $time, rst_n, flush, bus.in_valid, bus.out_valid, bus.out_ready, bus.in_ready,
             bus.dbus, bus.sw_mem, stall_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic v, input logic [DATA_W-1:0] a, input logic [SEL_W-1:0] d,
                       input logic [DATA_W-1:0] s, input logic w);
    bus.in_valid      = v;
    bus.alu_out_ex    = a;
    bus.dselect_ex    = d;
    bus.store_data_ex = s;
    bus.sw_ex         = w;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    offer(1'b1, 32'h5, 32'h1, 32'h7, 1'b1);

    // Reset held with traffic offered, then a three-entry stream
    tick(); tick();
    rst_n = 1'b1;
    offer(1'b1, 32'h10, 32'h2, 32'h0, 1'b0); tick();
    offer(1'b1, 32'h20, 32'h8, 32'h0, 1'b0); tick();
    offer(1'b1, 32'h30, 32'h10, 32'h0, 1'b0); tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();

    // Back-pressure fills main then skid, then drains in order
    bus.out_ready = 1'b0;
    offer(1'b1, 32'hA, 32'h1, 32'h0, 1'b0); tick();
    offer(1'b1, 32'hB, 32'h2, 32'h0, 1'b0); tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
    bus.out_ready = 1'b1;
    tick(); tick(); tick();

    // Store gating: sw_mem drops with out_valid while store data lingers
    offer(1'b1, 32'h40, 32'h4, 32'hDEADBEEF, 1'b1); tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick(); tick();

    // Flush while FULL with a new entry offered on the flush cycle
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h50, 32'h20, 32'h1, 1'b1); tick();
    offer(1'b1, 32'h60, 32'h40, 32'h2, 1'b1); tick();
    offer(1'b1, 32'h70, 32'h80, 32'h3, 1'b1); flush = 1'b1; tick();
    flush = 1'b0; offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); bus.out_ready = 1'b1; tick(); tick();

    // Reset in the middle of a stall
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h80, 32'h1, 32'h4, 1'b0); tick();
    offer(1'b1, 32'h90, 32'h2, 32'h5, 1'b1); tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();

    // Long stall: counter saturates when enabled, stays zero otherwise
    offer(1'b1, 32'hC0FFEE, 32'h100, 32'h9, 1'b1); tick();
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    bus.out_ready = 1'b1; tick(); tick();

    // Randomized traffic with rare flush and reset
    for (int i = 0; i < 400; i++) begin
      offer(1'($urandom_range(0, 3) != 0), $urandom, 32'h1 << $urandom_range(0, 31), $urandom,
            1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      rst_n         = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
- Parametrised, elastic EX/MEM pipeline register.
- Carries the ALU result, the destination select, the store data and the store-write flag from EX to MEM.
- Uses a valid/ready handshake with a one-entry skid buffer, so the MEM stage can stall without combinational ready paths back into EX. A synchronous flush squashes in-flight entries.
- Sits between the ALU/forwarding muxes (EX) and the data-memory interface (MEM).

Parameters:
- DATA_W, 32, width of the ALU result and store-data fields.
- SEL_W, 32, width of the one-hot destination-register select field.
- CNT_W, 16, width of the stall counter (used only with EXMEM_STALL_CNT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  squash all held entries (branch/exception).
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  register can accept the EX entry this cycle.
- alu_out_ex  in  DATA_W  ALU result.
- dselect_ex  in  SEL_W  destination select.
- store_data_ex  in  DATA_W  store data.
- sw_ex  in  1  store-word flag.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage accepts the entry.
- dbus  out  DATA_W  registered ALU result.
- dselect  out  SEL_W  registered destination select.
- databus_in  out  DATA_W  registered store data.
- sw_mem  out  1  registered store flag, gated by out_valid.
- stall_cnt  out  CNT_W  MEM back-pressure cycle count (optional).

Behaviour:
- **Reset** (rst_n=0 at a posedge):
  - out_valid=0, skid empty, dbus/dselect/databus_in=0, sw_mem=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset is released.
  - Reset overrides flush and all handshakes, including mid-transfer.
- **Storage:** main entry (drives the outputs) plus skid entry. Each entry is {alu, dsel, sdata, sw, valid}.
- **Handshakes:**
  - in_ready = ~skid_valid. It is a registered signal with no combinational path from out_ready.
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
- **States:** EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY, transfer in: load main -> ONE.
  - ONE, in only: if out_ready=0, load skid -> FULL.
  - ONE, out only: -> EMPTY.
  - ONE, in and out on the same cycle: load main with the new entry, stay ONE (one per cycle throughput).
  - ONE, neither: hold.
  - FULL, out: move skid into main, skid empty -> ONE. in_ready is 0, so no in-transfer is possible.
  - FULL, no out: hold all fields.
- **Latency and ordering:** one cycle from transfer in to out_valid in EMPTY. Ordering is strictly FIFO.
- **Field stability:** while out_valid=1 and out_ready=0, dbus, dselect, databus_in and sw_mem are stable.
- **sw_mem gating:** sw_mem = main.sw & out_valid. A store is never asserted with an invalid entry.
- **Data when invalid:** dbus, dselect and databus_in hold their last value while out_valid=0. They are not cleared.
- **Flush (synchronous):**
  - Clears main and skid valid -> EMPTY. An input offered that cycle is dropped.
  - Flush takes priority over any simultaneous transfer in or out.
  - in_ready=1 on the next cycle.
- **Widths:** no arithmetic; fields are passed bit-exact at the parameter widths.

Optional Feature:
- Macro: EXMEM_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with out_valid=1 & out_ready=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset; flush does not clear it.
- Undefined: stall_cnt is tied to 0, with no counter logic.

Test Plan:
1. Reset then stream. Hold rst_n=0 for 2 cycles with in_valid=1. Release, then drive alu_out_ex=0x00000010/0x20/0x30 on 3 consecutive cycles with out_ready=1.
   -> All outputs are 0 during reset. dbus shows 0x10, 0x20, 0x30 one cycle after each input; in_ready stays 1.
2. Back-pressure. Drive out_ready=0 and send entries A=0xA, then B=0xB.
   -> out_valid=1 with dbus=0xA held; in_ready goes 0 after B is loaded into skid.
   -> Raise out_ready: dbus=0xA, then 0xB on successive cycles, then out_valid=0.
3. Store gating. Send sw_ex=1 with store_data_ex=0xDEADBEEF and dselect_ex=0x00000004; after it is consumed, hold in_valid=0.
   -> sw_mem=1, databus_in=0xDEADBEEF for one cycle; sw_mem=0 once out_valid=0 while databus_in holds 0xDEADBEEF.
4. Flush while FULL, with in_valid=1 on the flush cycle.
   -> Next cycle out_valid=0, sw_mem=0, in_ready=1; the offered entry never appears on the outputs.
5. Reset mid-stall. Enter FULL, then assert rst_n=0 for 1 cycle.
   -> out_valid=0, dbus=0, stall_cnt=0, in_ready=1 after release.
6. With EXMEM_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles.
   -> stall_cnt saturates at 15. Without the macro, stall_cnt=0 throughout.
